vga_sync_decoder: RTL
=====================

Name: vga_sync_decoder

Overview:
- Receiver-side counterpart of the VGA sync generator.
- Takes active-low HSync/VSync (640x480 timing with porches) and rebuilds column/row counters where (0,0) is the first active pixel.
- Checks line and frame periods, reports lock, and flags timing errors.
- Used by capture, overlay and loopback-test paths to realign to an incoming sync stream.

Parameters:
- TOTAL_COLS, 800, clocks per line
- TOTAL_ROWS, 525, lines per frame
- ACTIVE_COLS, 640, visible columns
- ACTIVE_ROWS, 480, visible rows
- FRONT_PORCH_HORZ, 18, clocks between last active column and HSync fall
- FRONT_PORCH_VERT, 10, lines between last active row and VSync fall
- TIMEOUT_COLS, 1600, clocks without an HSync fall before lock is dropped

Ports:
- i_Clk  in  1  pixel clock
- i_Reset  in  1  asynchronous, active-high reset
- i_HSync  in  1  horizontal sync, active low
- i_VSync  in  1  vertical sync, active low
- o_Col_Count  out  10  recovered column, 0..TOTAL_COLS-1
- o_Row_Count  out  10  recovered row, 0..TOTAL_ROWS-1
- o_Active  out  1  high while locked and inside the 640x480 active area
- o_Locked  out  1  timing verified
- o_Frame_Start  out  1  one-clock pulse when locked and counts become (0,0)
- o_Error  out  1  one-clock pulse on a timing violation while LOCKED

Behaviour:
Reset:
- Clock i_Clk; reset i_Reset is asynchronous, active-high.
- While reset is high, all outputs are 0, all internal registers are 0, input sync flops are 1 (idle), FSM = SEARCH.

Input sampling:
- i_HSync and i_VSync each pass through a 2-flop synchroniser, then a third flop for edge detection.
- Falling edge = previous 1, current 0.
- Edge-to-counter-load latency: 3 clocks, fixed.

Column counter:
- On the clock where an HSync fall is detected: load H_START = ACTIVE_COLS + FRONT_PORCH_HORZ (658).
- Otherwise: increment; TOTAL_COLS-1 wraps to 0.
- The HSync-fall load always has priority over the wrap.

Row counter:
- Increments when the column counter wraps 799 -> 0; 524 wraps to 0.
- On a VSync fall detection: load V_START = ACTIVE_ROWS + FRONT_PORCH_VERT (490).
- The VSync load has priority over the column-wrap increment in the same clock.

Line-period counter (11 bits):
- Counts clocks since the last HSync fall; reset to 1 on each fall; saturates at 2047.

Lines-per-frame counter:
- Incremented on each HSync fall; cleared on each VSync fall.

FSM:
- SEARCH: wait for the first VSync fall -> ACQUIRE; clear the line-per-frame count.
- ACQUIRE: at each HSync fall, the line period must equal TOTAL_COLS (the first HSync fall after entry is exempt).
  - Mismatch -> SEARCH.
  - Next VSync fall with lines-per-frame = TOTAL_ROWS -> LOCKED.
  - Next VSync fall with any other count -> stay in ACQUIRE and restart the frame count.
- LOCKED: exit to SEARCH on any of:
  - line period ≠ TOTAL_COLS at an HSync fall;
  - VSync fall with lines-per-frame ≠ TOTAL_ROWS;
  - line-period counter reaching TIMEOUT_COLS.
  - On that clock, o_Error pulses for 1 clock and o_Locked clears.
- o_Locked is registered high in the clock the FSM enters LOCKED.

Active area and frame start:
- o_Active = o_Locked && col < ACTIVE_COLS && row < ACTIVE_ROWS. It is registered so that it aligns with the count outputs.
- o_Frame_Start pulses when locked and the counts step to (0,0); it does not pulse on counter loads.

Other rules:
- Counters free-run in every state, so counts are valid once the first edges arrive even before lock.
- Both sync falls in the same clock: both loads apply (col=658, row=490).
- Sync glitch shorter than 1 clock: may be missed; no requirement.
- Reset asserted mid-frame: immediate return to reset values; re-lock needs a full frame.

Test Plan:
- Reset, then drive the generator's nominal sync stream (HSync low cols 658..749, VSync low rows 490..491) -> o_Locked rises exactly one frame after the first VSync fall (about 1 frame + 3 clks); o_Frame_Start pulses once per 420000 clks; o_Active high for exactly 307200 clks per frame.
- Locked; compare o_Col_Count/o_Row_Count against the generator counts delayed 3 clks -> identical every clock for 2 frames.
- Locked; one line shortened to 799 clks -> o_Error pulses once, o_Locked and o_Active drop; re-lock after 1 further clean frame.
- Locked; HSync held high for 2000 clks -> o_Error at line-period 1600, FSM in SEARCH, o_Locked = 0.
- Frame with 524 lines during ACQUIRE -> no lock at that VSync; lock at the following clean VSync.
- i_Reset pulsed mid-frame (row 200, col 300) -> all outputs 0 asynchronously; after release, lock is recovered within 2 frames.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync decoder: recovers column/row counts and lock from HSync/VSync
//
// Ports:
//   i_Clk          pixel clock
//   i_Reset        asynchronous, active-high reset
//   i_HSync        horizontal sync, active low
//   i_VSync        vertical sync, active low
//   o_Col_Count    recovered column, 0..TOTAL_COLS-1 ((0,0) = first active pixel)
//   o_Row_Count    recovered row, 0..TOTAL_ROWS-1
//   o_Active       high while locked and inside the active area, aligned with the counts
//   o_Locked       line and frame periods verified
//   o_Frame_Start  one-clock pulse when locked and the counts wrap to (0,0)
//   o_Error        one-clock pulse on a timing violation while locked
module vga_sync_decoder #(
  parameter int TOTAL_COLS       = 800,
  parameter int TOTAL_ROWS       = 525,
  parameter int ACTIVE_COLS      = 640,
  parameter int ACTIVE_ROWS      = 480,
  parameter int FRONT_PORCH_HORZ = 18,
  parameter int FRONT_PORCH_VERT = 10,
  parameter int TIMEOUT_COLS     = 1600
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Locked,
  output logic       o_Frame_Start,
  output logic       o_Error
);

  localparam logic [9:0]  LP_H_START     = 10'(ACTIVE_COLS + FRONT_PORCH_HORZ);
  localparam logic [9:0]  LP_V_START     = 10'(ACTIVE_ROWS + FRONT_PORCH_VERT);
  localparam logic [9:0]  LP_COL_LAST    = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]  LP_ROW_LAST    = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0]  LP_ACTIVE_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0]  LP_ACTIVE_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0]  LP_TOTAL_ROWS  = 10'(TOTAL_ROWS);
  localparam logic [10:0] LP_TOTAL_COLS  = 11'(TOTAL_COLS);
  localparam logic [10:0] LP_TIMEOUT     = 11'(TIMEOUT_COLS);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  logic        r_h_meta, r_h_sync, r_h_prev;
  logic        r_v_meta, r_v_sync, r_v_prev;
  logic [9:0]  r_col, r_row;
  logic [10:0] r_line_period;
  logic [9:0]  r_lines;
  state_t      r_state;
  logic        r_first_line;
  logic        r_locked, r_error, r_active, r_frame_start;

  logic        w_h_fall, w_v_fall, w_col_wrap;
  logic [9:0]  w_col_next, w_row_next;
  logic        w_period_ok, w_frame_ok, w_timeout;
  logic        w_acq_fail, w_acq_lock, w_lock_fail, w_locked_next;

  // Two synchroniser flops plus one history flop per sync; idle level is high.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_h_meta <= 1'b1;
      r_h_sync <= 1'b1;
      r_h_prev <= 1'b1;
      r_v_meta <= 1'b1;
      r_v_sync <= 1'b1;
      r_v_prev <= 1'b1;
    end else begin
      r_h_meta <= i_HSync;
      r_h_sync <= r_h_meta;
      r_h_prev <= r_h_sync;
      r_v_meta <= i_VSync;
      r_v_sync <= r_v_meta;
      r_v_prev <= r_v_sync;
    end
  end

  assign w_h_fall = r_h_prev & ~r_h_sync;
  assign w_v_fall = r_v_prev & ~r_v_sync;

  // A sync load always overrides the free-running step, including the wrap.
  assign w_col_wrap = (r_col == LP_COL_LAST) && !w_h_fall;
  assign w_col_next = w_h_fall ? LP_H_START :
                      (r_col == LP_COL_LAST) ? 10'd0 : r_col + 10'd1;
  assign w_row_next = w_v_fall ? LP_V_START :
                      !w_col_wrap ? r_row :
                      (r_row == LP_ROW_LAST) ? 10'd0 : r_row + 10'd1;

  assign w_period_ok = (r_line_period == LP_TOTAL_COLS);
  assign w_frame_ok  = (r_lines == LP_TOTAL_ROWS);
  assign w_timeout   = (r_line_period == LP_TIMEOUT);

  // The line period seen at the first HSync after entering ACQUIRE spans an
  // unknown interval, so it is not judged.
  assign w_acq_fail    = (r_state == ACQUIRE) && w_h_fall && !r_first_line && !w_period_ok;
  assign w_acq_lock    = (r_state == ACQUIRE) && !w_acq_fail && w_v_fall && w_frame_ok;
  assign w_lock_fail   = (r_state == LOCKED) &&
                         ((w_h_fall && !w_period_ok) || (w_v_fall && !w_frame_ok) || w_timeout);
  assign w_locked_next = ((r_state == LOCKED) && !w_lock_fail) || w_acq_lock;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_col         <= 10'd0;
      r_row         <= 10'd0;
      r_line_period <= 11'd0;
      r_lines       <= 10'd0;
      r_active      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_col <= w_col_next;
      r_row <= w_row_next;

      if (w_h_fall)
        r_line_period <= 11'd1;
      else if (r_line_period != 11'h7FF)
        r_line_period <= r_line_period + 11'd1;

      if (w_v_fall)
        r_lines <= w_h_fall ? 10'd1 : 10'd0;
      else if (w_h_fall && r_lines != 10'h3FF)
        r_lines <= r_lines + 10'd1;

      // Built from the next counts so the flag lines up with the count outputs.
      r_active      <= w_locked_next && (w_col_next < LP_ACTIVE_COLS) && (w_row_next < LP_ACTIVE_ROWS);
      r_frame_start <= w_locked_next && !w_h_fall && !w_v_fall &&
                       (w_col_next == 10'd0) && (w_row_next == 10'd0);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state      <= SEARCH;
      r_first_line <= 1'b0;
      r_locked     <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_locked <= w_locked_next;
      r_error  <= w_lock_fail;
      case (r_state)
        SEARCH: begin
          if (w_v_fall) begin
            r_state      <= ACQUIRE;
            r_first_line <= 1'b1;
          end
        end
        ACQUIRE: begin
          if (w_acq_fail) begin
            r_state <= SEARCH;
          end else begin
            if (w_h_fall)
              r_first_line <= 1'b0;
            if (w_acq_lock)
              r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_lock_fail)
            r_state <= SEARCH;
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

  assign o_Col_Count   = r_col;
  assign o_Row_Count   = r_row;
  assign o_Active      = r_active;
  assign o_Locked      = r_locked;
  assign o_Frame_Start = r_frame_start;
  assign o_Error       = r_error;

endmodule
